// File: rtl/mcu_sequencer.sv
// mcu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I MCU core,
// with a per-wait memory watchdog. Define MCU_SEQ_INSTRET_EN to build the retired-instruction counter.
module mcu_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        is_branch_i,
  input  logic        is_jump_i,
  input  logic        is_load_i,
  input  logic        mem_wr_i,
  input  logic        rd_wr_i,
  input  logic        br_taken_i,
  input  logic        imem_ack_i,
  input  logic        dmem_ack_i,
  output logic        imem_req_o,
  output logic        ir_en_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        pc_en_o,
  output logic        pc_sel_o,
  output logic [2:0]  state_o,
  output logic        fault_o,
  output logic [31:0] instret_o
);

  localparam int              CW      = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   WD_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          st_q, st_d;
  logic          waiting;

  // Store/load direction is captured on entry to MEM so dmem_we_o cannot move under a live request.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack_i)             state_d = S_DECODE;
        else if (wd_q == WD_LAST)   state_d = S_FAULT;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_load_i || mem_wr_i) begin
          state_d = S_MEM;
          st_d    = mem_wr_i;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack_i)             state_d = st_q ? S_FETCH : S_WB;
        else if (wd_q == WD_LAST)   state_d = S_FAULT;
      end
      S_WB:    state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  // Watchdog restarts on every entry into a waiting state; an ack on the last cycle beats the fault.
  always_comb begin
    waiting = ((state_q == S_FETCH) && !imem_ack_i) ||
              ((state_q == S_MEM)   && !dmem_ack_i);
    wd_d = wd_q;
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
      wd_d = '0;
    else if (waiting)
      wd_d = wd_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      wd_q    <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      st_q    <= st_d;
    end
  end

  // Moore decode, forced low while reset is held so a live request drops in the reset cycle.
  always_comb begin
    imem_req_o = 1'b0;
    ir_en_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    wb_sel_o   = 2'b00;
    pc_en_o    = 1'b0;
    pc_sel_o   = 1'b0;
    fault_o    = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          imem_req_o = 1'b1;
          ir_en_o    = imem_ack_i;
        end
        S_MEM: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = st_q;
          pc_en_o    = dmem_ack_i && st_q;
        end
        S_WB: begin
          rf_we_o  = rd_wr_i;
          pc_en_o  = 1'b1;
          pc_sel_o = is_jump_i || (is_branch_i && br_taken_i);
          if (is_jump_i)      wb_sel_o = 2'b10;
          else if (is_load_i) wb_sel_o = 2'b01;
          else                wb_sel_o = 2'b00;
        end
        S_FAULT: fault_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = rst_i ? S_FETCH : state_q;

`ifdef MCU_SEQ_INSTRET_EN
  logic [31:0] instret_q;
  logic        retire;

  assign retire = (state_q == S_WB) || ((state_q == S_MEM) && dmem_ack_i && st_q);

  always_ff @(posedge clk_i) begin
    if (rst_i)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret_o = rst_i ? 32'd0 : instret_q;
`else
  assign instret_o = 32'd0;
`endif

endmodule

// File: tb/tb_mcu_sequencer.sv
// Bench for mcu_sequencer: random instruction stream against a latency/retire scoreboard,
// plus directed reset, watchdog and reset-during-MEM scenarios.
module tb_mcu_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        is_branch_i = 1'b0, is_jump_i = 1'b0, is_load_i = 1'b0, mem_wr_i = 1'b0;
  logic        rd_wr_i = 1'b0, br_taken_i = 1'b0, imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
  logic        imem_req_o, ir_en_o, dmem_req_o, dmem_we_o, rf_we_o, pc_en_o, pc_sel_o, fault_o;
  logic [1:0]  wb_sel_o;
  logic [2:0]  state_o;
  logic [31:0] instret_o;

  always #5 clk = ~clk;

`ifdef MCU_SEQ_INSTRET_EN
  localparam bit INSTRET_ON = 1'b1;
`else
  localparam bit INSTRET_ON = 1'b0;
`endif

  mcu_sequencer #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .is_branch_i(is_branch_i), .is_jump_i(is_jump_i), .is_load_i(is_load_i),
    .mem_wr_i(mem_wr_i), .rd_wr_i(rd_wr_i), .br_taken_i(br_taken_i),
    .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
    .imem_req_o(imem_req_o), .ir_en_o(ir_en_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
    .pc_en_o(pc_en_o), .pc_sel_o(pc_sel_o), .state_o(state_o),
    .fault_o(fault_o), .instret_o(instret_o)
  );

  wire [12:0] ctrl_outs = {imem_req_o, ir_en_o, dmem_req_o, dmem_we_o, rf_we_o, wb_sel_o,
                           pc_en_o, pc_sel_o, state_o, fault_o};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int         lat;
    int         ireq;
    int         dreq;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       pc_sel;
    logic       st;
    int         instret;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 1'b0;
  int   ret_cnt = 0;

  // Monitor: every retire (pc_en_o) pops one expected instruction record.
  int   m_cyc = 0, m_ireq = 0, m_dreq = 0;
  exp_t e;
  always begin
    @(negedge clk);
    #2;
    if (!mon_en) begin
      m_cyc = 0; m_ireq = 0; m_dreq = 0;
    end else begin
      m_cyc++;
      if (imem_req_o) m_ireq++;
      if (dmem_req_o) m_dreq++;
      chk("rf_we_outside_retire", 32'(rf_we_o & ~pc_en_o), 32'd0);
      if (pc_en_o) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_retire: got a retire, expected none (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("sb_latency",   32'(m_cyc),    32'(e.lat));
          chk("sb_imem_req",  32'(m_ireq),   32'(e.ireq));
          chk("sb_dmem_req",  32'(m_dreq),   32'(e.dreq));
          chk("sb_rf_we",     32'(rf_we_o),  32'(e.rf_we));
          chk("sb_wb_sel",    32'(wb_sel_o), 32'(e.wb_sel));
          chk("sb_pc_sel",    32'(pc_sel_o), 32'(e.pc_sel));
          chk("sb_dmem_we",   32'(dmem_we_o), 32'(e.st));
          chk("sb_instret",   instret_o,     32'(e.instret));
        end
        m_cyc = 0; m_ireq = 0; m_dreq = 0;
      end
    end
  end

  // Class: 0 ALU, 1 branch, 2 jump, 3 load, 4 store, 5 U-type. Called just after a falling edge.
  task automatic run_instr(input int cls, input int iw, input int dw);
    exp_t x;
    logic rdw, tk;
    int   ic, dc;
    bit   done;
    rdw = 1'($urandom_range(0, 1));
    tk  = 1'($urandom_range(0, 1));
    is_branch_i = (cls == 1);
    is_jump_i   = (cls == 2);
    is_load_i   = (cls == 3);
    mem_wr_i    = (cls == 4);
    rd_wr_i     = rdw;
    br_taken_i  = tk;
    x.lat     = 4 + iw + ((cls == 3) ? 1 + dw : (cls == 4) ? dw : 0);
    x.ireq    = iw + 1;
    x.dreq    = (cls == 3 || cls == 4) ? dw + 1 : 0;
    x.rf_we   = (cls == 4) ? 1'b0 : rdw;
    x.wb_sel  = (cls == 2) ? 2'b10 : (cls == 3) ? 2'b01 : 2'b00;
    x.pc_sel  = (cls == 2) || ((cls == 1) && tk);
    x.st      = (cls == 4);
    x.instret = INSTRET_ON ? ret_cnt : 0;
    ret_cnt++;
    q.push_back(x);
    ic = 0; dc = 0; done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      #1;
      imem_ack_i = imem_req_o && (ic == iw);
      if (imem_req_o) ic++;
      dmem_ack_i = dmem_req_o && (dc == dw);
      if (dmem_req_o) dc++;
      #1;
      if (pc_en_o) done = 1'b1;
      @(negedge clk);
    end
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL instr_timeout: got no retire in 100 cycles, expected one (class %0d)", cls);
    end
  endtask

  task automatic clear_inputs();
    is_branch_i = 1'b0; is_jump_i = 1'b0; is_load_i = 1'b0; mem_wr_i = 1'b0;
    rd_wr_i = 1'b0; br_taken_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  // Leaves the caller at the falling edge of the first FETCH cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_i  = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_i   = 1'b0;
    ret_cnt = 0;
  endtask

  task automatic post_release_checks();
    #2;
    chk("rel_state",    32'(state_o),    32'd0);
    chk("rel_imem_req", 32'(imem_req_o), 32'd1);
    chk("rel_fault",    32'(fault_o),    32'd0);
    chk("rel_instret",  instret_o,       32'd0);
  endtask

  int es[5] = '{0, 1, 2, 4, 0};
  int ew[5] = '{0, 0, 0, 1, 0};

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_ctrl_outs", 32'(ctrl_outs), 32'd0);
    chk("rst_instret",   instret_o,      32'd0);

    // ALU with imem ack tied high and rd_wr set.
    @(negedge clk);
    rst_i = 1'b0;
    rd_wr_i = 1'b1;
    imem_ack_i = 1'b1;
    post_release_checks();
    for (int c = 0; c < 5; c++) begin
      if (c != 0) #2;
      chk("alu_state", 32'(state_o), 32'(es[c]));
      chk("alu_rf_we", 32'(rf_we_o), 32'(ew[c]));
      chk("alu_pc_en", 32'(pc_en_o), 32'(ew[c]));
      if (c == 3) begin
        chk("alu_wb_sel", 32'(wb_sel_o), 32'd0);
        chk("alu_pc_sel", 32'(pc_sel_o), 32'd0);
      end
      @(negedge clk);
    end

    // Random instruction stream.
    do_reset();
    mon_en = 1'b1;
    for (int n = 0; n < 60; n++)
      run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    mon_en = 1'b0;
    chk("sb_drain_random", 32'(q.size()), 32'd0);

    // Fetch watchdog: 16 unanswered FETCH cycles, then FAULT held until reset.
    do_reset();
    repeat (15) @(negedge clk);
    #2;
    chk("wd_i_cycle16_state", 32'(state_o), 32'd0);
    chk("wd_i_cycle16_fault", 32'(fault_o), 32'd0);
    @(negedge clk);
    #2;
    chk("wd_i_fault_state", 32'(state_o),    32'd7);
    chk("wd_i_fault",       32'(fault_o),    32'd1);
    chk("wd_i_fault_req",   32'(imem_req_o), 32'd0);
    imem_ack_i = 1'b1;
    dmem_ack_i = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk("wd_i_hold_state", 32'(state_o), 32'd7);
    chk("wd_i_hold_fault", 32'(fault_o), 32'd1);
    chk("wd_i_hold_ir_en", 32'(ir_en_o), 32'd0);

    // Ack on the 16th FETCH cycle wins over the watchdog.
    do_reset();
    repeat (15) @(negedge clk);
    #1;
    imem_ack_i = 1'b1;
    #1;
    chk("wd_ack16_ir_en", 32'(ir_en_o), 32'd1);
    @(negedge clk);
    imem_ack_i = 1'b0;
    #2;
    chk("wd_ack16_state", 32'(state_o), 32'd1);
    chk("wd_ack16_fault", 32'(fault_o), 32'd0);

    // Data watchdog: load whose dmem ack never comes.
    do_reset();
    is_load_i  = 1'b1;
    imem_ack_i = 1'b1;
    @(negedge clk);
    imem_ack_i = 1'b0;
    repeat (17) @(negedge clk);
    #2;
    chk("wd_d_last_state", 32'(state_o),    32'd3);
    chk("wd_d_last_req",   32'(dmem_req_o), 32'd1);
    @(negedge clk);
    #2;
    chk("wd_d_fault_state", 32'(state_o),    32'd7);
    chk("wd_d_fault_req",   32'(dmem_req_o), 32'd0);
    chk("wd_d_fault",       32'(fault_o),    32'd1);

    // Reset in the middle of a load's MEM wait.
    do_reset();
    is_load_i  = 1'b1;
    rd_wr_i    = 1'b1;
    imem_ack_i = 1'b1;
    @(negedge clk);
    imem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("mid_mem_state", 32'(state_o),    32'd3);
    chk("mid_mem_req",   32'(dmem_req_o), 32'd1);
    @(negedge clk);
    rst_i = 1'b1;
    dmem_ack_i = 1'b1;
    #2;
    chk("mid_mem_rst_outs",    32'(ctrl_outs), 32'd0);
    chk("mid_mem_rst_instret", instret_o,      32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    clear_inputs();
    ret_cnt = 0;
    mon_en = 1'b1;
    fork
      post_release_checks();
    join_none
    for (int n = 0; n < 3; n++)
      run_instr(0, int'($urandom_range(0, 2)), 0);
    #2;
    chk("instret_after_3", instret_o, INSTRET_ON ? 32'd3 : 32'd0);
    mon_en = 1'b0;
    chk("sb_drain_final", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mcu_sequencer.md
# mcu_sequencer

Multi-cycle control sequencer for the RV32I MCU core. It steps each instruction through fetch, decode, execute, memory and writeback. It issues request/acknowledge handshakes to instruction and data memory, and generates the PC, IR, register-file and writeback-mux enables from the decoder's class flags. It has a watchdog per memory wait, and an optional retired-instruction counter.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent waiting for a memory ack before faulting; must be ≥2.
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: synchronous reset, active-high.
- `is_branch_i`, `is_jump_i`, `is_load_i`, `mem_wr_i`, `rd_wr_i`  in  1 each: decoder class flags; valid from DECODE until the instruction retires.
- `br_taken_i`  in  1: branch comparator result; valid in WB.
- `imem_ack_i`  in  1: instruction memory data valid.
- `dmem_ack_i`  in  1: data memory access complete.
- `imem_req_o`  out  1: instruction fetch request.
- `ir_en_o`  out  1: latch the instruction register.
- `dmem_req_o`  out  1: data memory request.
- `dmem_we_o`  out  1: data memory write strobe; valid with `dmem_req_o`.
- `rf_we_o`  out  1: register-file write enable.
- `wb_sel_o`  out  2: writeback source; 00 = ALU, 01 = load data, 10 = PC+4.
- `pc_en_o`  out  1: PC update enable.
- `pc_sel_o`  out  1: PC source; 0 = PC+4, 1 = ALU target.
- `state_o`  out  3: current state encoding.
- `fault_o`  out  1: sticky memory-timeout fault.
- `instret_o`  out  32: retired-instruction count.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 7. Encodings 5 and 6 are unused and go to FETCH on the next cycle.
- FETCH
  - `imem_req_o` = 1.
  - On `imem_ack_i`: `ir_en_o` = 1 in the same cycle, and the next state is DECODE.
- DECODE: lasts one cycle, then EXEC.
- EXEC: lasts one cycle.
  - If `is_load_i` | `mem_wr_i`, the next state is MEM; otherwise WB.
- MEM
  - `dmem_req_o` = 1, and `dmem_we_o` = `mem_wr_i`.
  - On `dmem_ack_i` with a load: next state is WB.
  - On `dmem_ack_i` with a store: `pc_en_o` = 1 and `pc_sel_o` = 0 in that cycle, and the next state is FETCH (the store retires).
- WB: lasts one cycle, then FETCH; the instruction retires.
  - `rf_we_o` = `rd_wr_i`.
  - `pc_en_o` = 1.
  - `pc_sel_o` = `is_jump_i` | (`is_branch_i` & `br_taken_i`).
  - `wb_sel_o` = 10 if `is_jump_i`, 01 if `is_load_i`, 00 otherwise.
- Output rules:
  - All outputs are Moore (decoded from state), except `ir_en_o` and the store-path `pc_en_o`, which are gated by the ack.
  - Any output not listed for the current state is 0.
- Request handshake:
  - A request stays high continuously until its ack arrives.
  - An ack received in a state that is not waiting on it is ignored.
  - `dmem_we_o` does not change while `dmem_req_o` is high.
- Watchdog
  - A `$clog2(TIMEOUT)+1`-bit counter clears on entry to FETCH or MEM.
  - It increments each cycle that the state waits without an ack.
  - If the counter reaches `TIMEOUT` with no ack, the next state is FAULT.
  - An ack in the same cycle the counter reaches `TIMEOUT` wins: normal progress, no fault.
- FAULT
  - `fault_o` = 1; all request and enable outputs are 0.
  - Only `rst_i` exits FAULT.

## Timing
- Reset values: state = FETCH, watchdog = 0, `fault_o` = 0, `instret_o` = 0.
- While `rst_i` is high, all outputs are 0.
- In the first cycle after `rst_i` deasserts, `imem_req_o` = 1.
- Latency with zero-wait memory (ack in the same cycle as the request):

| Instruction class | Cycles | States |
|---|---|---|
| ALU, branch, jump, U-type | 4 | FETCH, DECODE, EXEC, WB |
| Load | 5 | FETCH, DECODE, EXEC, MEM, WB |
| Store | 4 | FETCH, DECODE, EXEC, MEM |

- Each memory wait cycle adds one cycle to the total.
- Reset during MEM or FETCH: the request drops in the same cycle as reset, no retire or write occurs, and the sequencer restarts in FETCH.

## Configuration
- Macro: `MCU_SEQ_INSTRET_EN`.
- Defined:
  - `instret_o` increments by 1 in each retire cycle (WB, or MEM with store ack).
  - It wraps from 0xFFFFFFFF to 0.
- Undefined: the counter is not built and `instret_o` is tied to 0. The port list is unchanged.

## Test plan
- ALU instruction, `imem_ack_i` tied to 1, `rd_wr_i` = 1:
  - `state_o` sequence is 0, 1, 2, 4, 0.
  - `rf_we_o` and `pc_en_o` are 1 only in cycle 4, with `wb_sel_o` = 00 and `pc_sel_o` = 0.
- Load with `dmem_ack_i` delayed 3 cycles:
  - `dmem_req_o` stays high for 4 cycles with `dmem_we_o` = 0.
  - WB follows with `wb_sel_o` = 01 and `rf_we_o` = 1.
  - Total is 8 cycles.
- Store with zero-wait memory:
  - `dmem_we_o` = 1 and `pc_en_o` = 1 in the MEM ack cycle, followed by FETCH.
  - `rf_we_o` is never 1.
- Branch with `br_taken_i` = 1: `pc_sel_o` = 1 in WB. The same branch with `br_taken_i` = 0 gives `pc_sel_o` = 0.
- Jump: `pc_sel_o` = 1 and `wb_sel_o` = 10 in WB.
- Watchdog, `TIMEOUT` = 16:
  - With no `imem_ack_i`, `fault_o` = 1 after 16 wait cycles, and the sequencer holds FAULT until `rst_i`.
  - An ack in cycle 16 proceeds to DECODE with no fault.
- Reset asserted mid-MEM:
  - Outputs go to 0 while reset is high.
  - After release, `state_o` = 0 and `imem_req_o` = 1.
  - With the macro defined, `instret_o` = 0; after 3 ALU instructions, `instret_o` = 3.
